// File: rtl/cpu_datapath_if.sv
// Control/status bundle between control_unit (master) and the datapath (slave).
// Signal names follow the processor's established control-word naming.
interface cpu_datapath_if #(
  parameter int DATA_W = 9,
  parameter int NREGS  = 8
);
  logic              run;
  logic [DATA_W-1:0] DIN;
  logic              IRin;
  logic              DINout;
  logic              Gout;
  logic [2:0]        Rout;
  logic [NREGS-1:0]  Rin;
  logic              Ain;
  logic              Gin;
  logic [1:0]        alu_op;
  logic              clear;
  logic [2:0]        dbg_sel;

  logic [8:0]        IR;
  logic [1:0]        counter;
  logic [DATA_W-1:0] BusWires;
  logic [DATA_W-1:0] dbg_reg;

  modport master (
    output run, DIN, IRin, DINout, Gout, Rout, Rin, Ain, Gin, alu_op, clear, dbg_sel,
    input  IR, counter, BusWires, dbg_reg
  );

  modport slave (
    input  run, DIN, IRin, DINout, Gout, Rout, Rin, Ain, Gin, alu_op, clear, dbg_sel,
    output IR, counter, BusWires, dbg_reg
  );
endinterface

// File: rtl/cpu_datapath.sv
// Register-transfer datapath of the 9-bit multi-cycle processor: IR, R0..R(NREGS-1),
// A, G, ALU, shared bus and the 2-bit step counter. No opcode decoding lives here.
module cpu_datapath #(
  parameter int DATA_W = 9,
  parameter int NREGS  = 8
) (
  input logic           clock,
  input logic           reset,
  cpu_datapath_if.slave dp
);

  typedef enum logic [1:0] {
    ALU_PASS = 2'b00,
    ALU_ADD  = 2'b01,
    ALU_SUB  = 2'b10,
    ALU_RSVD = 2'b11
  } alu_op_e;

  logic [DATA_W-1:0] regs [NREGS];
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] g_q;
  logic [8:0]        ir_q;
  logic [1:0]        cnt_q;

  logic [DATA_W-1:0] r_sel;
  logic [DATA_W-1:0] dbg_sel_val;
  logic [DATA_W-1:0] bus_w;
  logic [DATA_W-1:0] alu_y;
  alu_op_e           op;

  assign op = alu_op_e'(dp.alu_op);

  // Register read ports; an index beyond NREGS reads as zero.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    r_sel       = '0;
    dbg_sel_val = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (dp.Rout == 3'(i))    r_sel       = regs[i];
      if (dp.dbg_sel == 3'(i)) dbg_sel_val = regs[i];
    end
  end

  // Fixed-priority bus: DIN over G over the register file.
  always_comb begin
    bus_w = r_sel;
    if (dp.DINout)    bus_w = dp.DIN;
    else if (dp.Gout) bus_w = g_q;
  end

  // Unsigned modulo-2^DATA_W arithmetic; carry/borrow simply fall off the top.
  always_comb begin
    alu_y = bus_w;
    case (op)
      ALU_ADD:  alu_y = a_q + bus_w;
      ALU_SUB:  alu_y = a_q - bus_w;
      default:  alu_y = bus_w;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      // NOTE: the register file is cleared on reset because software relies on R0-R7 starting at zero.
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (dp.Rin[i]) regs[i] <= bus_w;
      end
    end
  end

  // NOTE: state uses non-blocking assignments so G samples the pre-edge A even when Ain and Gin fire together.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a_q <= '0;
      g_q <= '0;
    end else begin
      if (dp.Ain) a_q <= bus_w;
      if (dp.Gin) g_q <= alu_y;
    end
  end

  // IR loads straight from DIN, never from the bus.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)        ir_q <= '0;
    else if (dp.IRin) ir_q <= dp.DIN[8:0];
  end

  // Step counter: clear wins over run; natural 2-bit wrap 3 -> 0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)        cnt_q <= '0;
    else if (dp.clear) cnt_q <= '0;
    else if (dp.run)  cnt_q <= cnt_q + 2'd1;
  end

  assign dp.IR       = ir_q;
  assign dp.counter  = cnt_q;
  assign dp.BusWires = bus_w;
  assign dp.dbg_reg  = dbg_sel_val;

endmodule

// File: tb/tb_cpu_datapath.sv
// Directed and randomized checks of cpu_datapath against a behavioural model of
// the register-transfer rules (bus priority, ALU, register writes, step counter).
module tb_cpu_datapath;

  localparam int DATA_W = 9;
  localparam int NREGS  = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;

  int n_checks = 0;
  int n_err    = 0;

  cpu_datapath_if #(.DATA_W(DATA_W), .NREGS(NREGS)) dp_if ();

  cpu_datapath #(.DATA_W(DATA_W), .NREGS(NREGS)) dut (
    .clock (clock),
    .reset (reset),
    .dp    (dp_if.slave)
  );

  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Behavioural model state.
  logic [8:0] m_r [NREGS];
  logic [8:0] m_a, m_g, m_ir;
  int         m_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    dp_if.run     = 1'b0;
    dp_if.DIN     = '0;
    dp_if.IRin    = 1'b0;
    dp_if.DINout  = 1'b0;
    dp_if.Gout    = 1'b0;
    dp_if.Rout    = 3'd0;
    dp_if.Rin     = '0;
    dp_if.Ain     = 1'b0;
    dp_if.Gin     = 1'b0;
    dp_if.alu_op  = 2'b00;
    dp_if.clear   = 1'b0;
    dp_if.dbg_sel = 3'd0;
  endtask

  task automatic load_reg(input int idx, input logic [8:0] val);
    idle();
    dp_if.DIN    = val;
    dp_if.DINout = 1'b1;
    dp_if.Rin    = 8'(1 << idx);
    tick();
    idle();
  endtask

  task automatic load_a(input logic [8:0] val);
    idle();
    dp_if.DIN    = val;
    dp_if.DINout = 1'b1;
    dp_if.Ain    = 1'b1;
    tick();
    idle();
  endtask

  task automatic check_reg(input string tag, input int idx, input logic [8:0] exp);
    dp_if.dbg_sel = 3'(idx);
    #1;
    check(tag, 32'(dp_if.dbg_reg), 32'(exp));
  endtask

  task automatic check_g(input string tag, input logic [8:0] exp);
    dp_if.Gout = 1'b1;
    #1;
    check(tag, 32'(dp_if.BusWires), 32'(exp));
    dp_if.Gout = 1'b0;
  endtask

  initial begin
    logic [8:0] exp_bus;
    logic [8:0] exp_alu;

    idle();
    repeat (2) tick();

    // Reset state
    check("rst_ir", 32'(dp_if.IR), 32'h0);
    check("rst_cnt", 32'(dp_if.counter), 32'h0);
    check("rst_bus", 32'(dp_if.BusWires), 32'h0);
    for (int i = 0; i < NREGS; i++) check_reg($sformatf("rst_r%0d", i), i, 9'h000);
    reset = 1'b0;
    tick();
    check_g("rst_g", 9'h000);

    // MVI path
    idle();
    dp_if.DIN    = 9'h0AB;
    dp_if.DINout = 1'b1;
    dp_if.Rin    = 8'b0000_0100;
    #1;
    check("mvi_bus", 32'(dp_if.BusWires), 32'h0AB);
    tick();
    idle();
    check_reg("mvi_r2", 2, 9'h0AB);

    // Read-during-write: old value seen before the edge, new one after
    dp_if.DIN     = 9'h155;
    dp_if.DINout  = 1'b1;
    dp_if.Rin     = 8'b0000_0100;
    check_reg("rdw_old", 2, 9'h0AB);
    tick();
    idle();
    check_reg("rdw_new", 2, 9'h155);

    // IR loads from DIN even when the bus shows G
    dp_if.DIN  = 9'h1C5;
    dp_if.IRin = 1'b1;
    dp_if.Gout = 1'b1;
    tick();
    idle();
    check("ir_load", 32'(dp_if.IR), 32'h1C5);
    tick();
    check("ir_hold", 32'(dp_if.IR), 32'h1C5);

    // ADD wrap
    load_reg(1, 9'h002);
    load_a(9'h1FF);
    dp_if.Rout   = 3'd1;
    dp_if.Gin    = 1'b1;
    dp_if.alu_op = 2'b01;
    tick();
    idle();
    check_g("add_wrap_g", 9'h001);
    dp_if.Gout = 1'b1;
    dp_if.Rin  = 8'h80;
    tick();
    idle();
    check_reg("add_r7", 7, 9'h001);

    // SUB borrow
    load_reg(4, 9'h005);
    load_a(9'h003);
    dp_if.Rout   = 3'd4;
    dp_if.alu_op = 2'b10;
    dp_if.Gin    = 1'b1;
    tick();
    idle();
    check_g("sub_borrow_g", 9'h1FE);

    // Counter
    dp_if.clear = 1'b1;
    tick();
    idle();
    check("cnt_clr0", 32'(dp_if.counter), 32'h0);
    dp_if.run = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check($sformatf("cnt_run%0d", k), 32'(dp_if.counter), 32'(k % 4));
    end
    dp_if.run = 1'b0;
    repeat (2) tick();
    check("cnt_hold", 32'(dp_if.counter), 32'h1);
    dp_if.run = 1'b1;
    tick();
    check("cnt_at2", 32'(dp_if.counter), 32'h2);
    dp_if.clear = 1'b1;
    tick();
    check("cnt_clr_run", 32'(dp_if.counter), 32'h0);
    dp_if.clear = 1'b0;
    tick();
    dp_if.run   = 1'b0;
    dp_if.clear = 1'b1;
    tick();
    idle();
    check("cnt_clr_norun", 32'(dp_if.counter), 32'h0);

    // Bus priority
    load_reg(5, 9'h055);
    dp_if.DIN    = 9'h0F0;
    dp_if.DINout = 1'b1;
    dp_if.Gin    = 1'b1;
    dp_if.alu_op = 2'b00;
    tick();
    idle();
    dp_if.DINout = 1'b1;
    dp_if.Gout   = 1'b1;
    dp_if.Rout   = 3'd5;
    dp_if.DIN    = 9'h123;
    #1;
    check("prio_din", 32'(dp_if.BusWires), 32'h123);
    dp_if.DINout = 1'b0;
    #1;
    check("prio_g", 32'(dp_if.BusWires), 32'h0F0);
    dp_if.Gout = 1'b0;
    #1;
    check("prio_reg", 32'(dp_if.BusWires), 32'h055);
    // Reserved op behaves as pass; Gin with Gout uses old G
    idle();
    dp_if.Gout   = 1'b1;
    dp_if.Gin    = 1'b1;
    dp_if.alu_op = 2'b11;
    tick();
    idle();
    check_g("rsvd_pass_g", 9'h0F0);

    // Reset mid-op
    load_reg(3, 9'h005);
    load_a(9'h011);
    dp_if.clear = 1'b1;
    tick();
    idle();
    dp_if.run = 1'b1;
    repeat (2) tick();
    check("mid_cnt_pre", 32'(dp_if.counter), 32'h2);
    check_reg("mid_r3_pre", 3, 9'h005);
    dp_if.DIN    = 9'h1FF;
    dp_if.DINout = 1'b1;
    dp_if.Rin    = 8'hFF;
    dp_if.Ain    = 1'b1;
    dp_if.Gin    = 1'b1;
    dp_if.IRin   = 1'b1;
    reset = 1'b1;
    #1;
    check("mid_cnt", 32'(dp_if.counter), 32'h0);
    check("mid_ir", 32'(dp_if.IR), 32'h0);
    check("mid_bus_din", 32'(dp_if.BusWires), 32'h1FF);
    check_reg("mid_r3", 3, 9'h000);
    idle();
    #1;
    reset = 1'b0;
    tick();
    check_g("mid_g", 9'h000);
    dp_if.Rout   = 3'd0;
    dp_if.alu_op = 2'b01;
    dp_if.Gin    = 1'b1;
    tick();
    idle();
    check_g("mid_a_zero", 9'h000);

    // Randomized run against the behavioural model, from a clean reset
    reset = 1'b1;
    #1;
    reset = 1'b0;
    for (int i = 0; i < NREGS; i++) m_r[i] = '0;
    m_a = '0; m_g = '0; m_ir = '0; m_cnt = 0;
    tick();

    for (int it = 0; it < 400; it++) begin
      dp_if.DIN     = 9'($urandom_range(0, 511));
      dp_if.DINout  = ($urandom % 4) == 0;
      dp_if.Gout    = ($urandom % 3) == 0;
      dp_if.Rout    = 3'($urandom);
      dp_if.Rin     = 8'($urandom) & 8'($urandom);
      dp_if.Ain     = 1'($urandom);
      dp_if.Gin     = 1'($urandom);
      dp_if.alu_op  = 2'($urandom);
      dp_if.run     = 1'($urandom);
      dp_if.clear   = ($urandom % 5) == 0;
      dp_if.IRin    = ($urandom % 3) == 0;
      dp_if.dbg_sel = 3'($urandom);
      #1;

      if (dp_if.DINout)    exp_bus = dp_if.DIN;
      else if (dp_if.Gout) exp_bus = m_g;
      else                 exp_bus = m_r[dp_if.Rout];
      check("rnd_bus", 32'(dp_if.BusWires), 32'(exp_bus));
      check("rnd_dbg", 32'(dp_if.dbg_reg), 32'(m_r[dp_if.dbg_sel]));

      case (dp_if.alu_op)
        2'b01:   exp_alu = 9'((int'(m_a) + int'(exp_bus)) % 512);
        2'b10:   exp_alu = 9'((int'(m_a) - int'(exp_bus) + 512) % 512);
        default: exp_alu = exp_bus;
      endcase
      for (int r = 0; r < NREGS; r++) if (dp_if.Rin[r]) m_r[r] = exp_bus;
      if (dp_if.Gin)  m_g  = exp_alu;
      if (dp_if.Ain)  m_a  = exp_bus;
      if (dp_if.IRin) m_ir = dp_if.DIN;
      if (dp_if.clear)    m_cnt = 0;
      else if (dp_if.run) m_cnt = (m_cnt + 1) % 4;

      tick();
      check("rnd_ir", 32'(dp_if.IR), 32'(m_ir));
      check("rnd_cnt", 32'(dp_if.counter), 32'(m_cnt));
    end

    idle();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
